rob_alloc: RTL and testbench

//  In-order ROB slot allocator. Sits at decode/issue, directly upstream of the rob.

---
 rtl/rob_alloc_if.sv | 29 ++
 rtl/rob_alloc.sv | 94 +++++++++
 tb/tb_rob_alloc.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rob_alloc_if.sv
// Issue/retire handshake between decode and the ROB slot allocator.
// Latency: none, bundle of wires only.
// Backpressure: reqReady from the allocator throttles reqValid from decode.
interface rob_alloc_if #(
    parameter int ROB_IDX_BITS = 4
);
    logic                    clear;
    logic                    reqValid;
    logic                    reqReady;
    logic [ROB_IDX_BITS-1:0] robIdx;
    logic                    retire;
    logic [ROB_IDX_BITS:0]   count;
    logic                    full;
    logic                    empty;
    logic                    draining;
    logic                    underflow;

    // Decode / flush / ROB-retire side
    modport master (
        output clear, reqValid, retire,
        input  reqReady, robIdx, count, full, empty, draining, underflow
    );

    // Allocator side
    modport slave (
        input  clear, reqValid, retire,
        output reqReady, robIdx, count, full, empty, draining, underflow
    );
endinterface

// File: rtl/rob_alloc.sv
// In-order ROB slot allocator: hands out tail index, tracks occupancy, drains after flush.
// Latency: robIdx/reqReady combinational; count/full/empty/underflow registered (1 cycle).
// Backpressure: reqReady low when full, during clear, or for DRAIN_CYCLES after a clear.
module rob_alloc #(
    parameter int ROB_POSITIONS = 16,
    parameter int ROB_IDX_BITS  = 4,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    rob_alloc_if.slave   bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ROB_IDX_BITS:0] CNT_FULL = (ROB_IDX_BITS+1)'(ROB_POSITIONS);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                  state_q, state_nxt;
    logic [DW-1:0]           drain_cnt, drain_cnt_nxt;
    logic [ROB_IDX_BITS-1:0] tail;
    logic [ROB_IDX_BITS:0]   count_q;
    logic                    underflow_q;

    logic full, empty, ready, fire, valid_retire, bad_retire;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    // A full ROB never reuses a slot in the same cycle it retires; issue waits one cycle.
    assign ready = (state_q == RUN) && !full && !bus.clear;
    assign fire  = bus.reqValid && ready;
    // Retires coinciding with a clear are discarded along with everything else in flight.
    assign valid_retire = bus.retire && !empty && !bus.clear;
    assign bad_retire   = bus.retire &&  empty && !bus.clear;

    assign bus.reqReady  = ready;
    assign bus.robIdx    = tail;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.draining  = (state_q == DRAIN);
    assign bus.underflow = underflow_q;

    // Next-state for the post-flush drain window; a clear always (re)starts it.
    always_comb begin
        state_nxt     = state_q;
        drain_cnt_nxt = drain_cnt;
        case (state_q)
            RUN: ;
            DRAIN: begin
                if (drain_cnt == '0) state_nxt = RUN;
                else                 drain_cnt_nxt = drain_cnt - 1'b1;
            end
            default: state_nxt = RUN;
        endcase
        if (bus.clear) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
        end
    end

    // FSM register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            drain_cnt <= '0;
        end else begin
            state_q   <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Tail pointer, occupancy and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tail        <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (bad_retire) underflow_q <= 1'b1;
            if (bus.clear) begin
                tail    <= '0;
                count_q <= '0;
            end else begin
                if (fire) tail <= tail + 1'b1;
                case ({fire, valid_retire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc with a queue-free occupancy model and per-cycle compare.
// Latency: inputs applied 1ns after posedge, outputs checked around negedge.
// Backpressure: model predicts reqReady from occupancy and remaining blocked cycles.
module tb_rob_alloc;
    localparam int N     = 16;
    localparam int DRAIN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rob_alloc_if #(.ROB_IDX_BITS(4)) bus ();

    rob_alloc #(.ROB_POSITIONS(N), .ROB_IDX_BITS(4), .DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: occupancy as an integer, tail as a modular counter, and the number of
    // blocked cycles still owed after a flush.
    int m_tail  = 0;
    int m_count = 0;
    int m_block = 0;
    bit m_under = 1'b0;
    bit m_ok    = 1'b0;

    function automatic bit m_ready();
        return (m_block == 0) && (m_count < N) && !bus.clear;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_tail = 0; m_count = 0; m_block = 0; m_under = 1'b0; m_ok = 1'b1;
        end else if (m_ok) begin
            if (bus.clear) begin
                m_tail = 0; m_count = 0; m_block = DRAIN;
            end else begin
                bit f;
                bit r;
                f = bus.reqValid && m_ready();
                r = bus.retire && (m_count > 0);
                if (bus.retire && m_count == 0) m_under = 1'b1;
                if (f) m_tail = (m_tail + 1) % N;
                m_count = m_count + int'(f) - int'(r);
                if (m_block > 0) m_block--;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_reqReady", int'(bus.reqReady), int'(m_ready()));
            chk("m_robIdx",   int'(bus.robIdx),   m_tail);
            chk("m_count",    int'(bus.count),    m_count);
            chk("m_full",     int'(bus.full),     int'(m_count == N));
            chk("m_empty",    int'(bus.empty),    int'(m_count == 0));
            chk("m_draining", int'(bus.draining), int'(m_block > 0));
            chk("m_underflow",int'(bus.underflow),int'(m_under));
        end
    end

    // One cycle: apply inputs after the edge, return with outputs settled mid-cycle.
    task automatic go(input bit v, input bit r, input bit c, input bit rs);
        @(posedge clk);
        #1;
        bus.reqValid = v;
        bus.retire   = r;
        bus.clear    = c;
        rst          = rs;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.reqValid = 1'b0;
        bus.retire   = 1'b0;
        bus.clear    = 1'b0;

        // Reset values
        go(0, 0, 0, 1);
        go(0, 0, 0, 0);
        chk("rst_reqReady", int'(bus.reqReady), 1);
        chk("rst_robIdx",   int'(bus.robIdx),   0);
        chk("rst_full",     int'(bus.full),     0);
        chk("rst_empty",    int'(bus.empty),    1);
        chk("rst_draining", int'(bus.draining), 0);
        chk("rst_underflow",int'(bus.underflow),0);

        // 1: fill 16 slots, robIdx 0..15, then full
        for (int i = 0; i < 16; i++) begin
            go(1, 0, 0, 0);
            chk("t1_robIdx", int'(bus.robIdx), i);
            chk("t1_ready",  int'(bus.reqReady), 1);
        end
        go(1, 0, 0, 0);
        chk("t1_count",   int'(bus.count),    16);
        chk("t1_full",    int'(bus.full),     1);
        chk("t1_ready17", int'(bus.reqReady), 0);

        // 2: retire while full blocks same-cycle reuse
        go(1, 1, 0, 0);
        chk("t2_ready_full", int'(bus.reqReady), 0);
        go(1, 0, 0, 0);
        chk("t2_count", int'(bus.count),    15);
        chk("t2_ready", int'(bus.reqReady), 1);
        chk("t2_robIdx",int'(bus.robIdx),   0);

        // 3: count=5, fire+retire for 20 cycles, tail wraps
        go(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) go(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            go(1, 1, 0, 0);
            chk("t3_count",  int'(bus.count),  5);
            chk("t3_robIdx", int'(bus.robIdx), (5 + i) % 16);
        end
        go(0, 0, 0, 0);
        chk("t3_count_end", int'(bus.count),  5);
        chk("t3_tail_end",  int'(bus.robIdx), 9);

        // 4: count=7 tail=9, clear, 4 blocked cycles, then issue from slot 0
        go(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) go(1, 0, 0, 0);
        go(0, 1, 0, 0);
        go(0, 1, 0, 0);
        go(1, 0, 1, 0);
        chk("t4_pre_count", int'(bus.count),    7);
        chk("t4_pre_tail",  int'(bus.robIdx),   9);
        chk("t4_clr_ready", int'(bus.reqReady), 0);
        for (int i = 0; i < 4; i++) begin
            go(1, 0, 0, 0);
            chk("t4_drain_ready", int'(bus.reqReady), 0);
            chk("t4_draining",    int'(bus.draining), 1);
            chk("t4_count",       int'(bus.count),    0);
        end
        go(1, 0, 0, 0);
        chk("t4_resume_ready", int'(bus.reqReady), 1);
        chk("t4_resume_idx",   int'(bus.robIdx),   0);
        go(0, 0, 0, 0);
        chk("t4_count_after",  int'(bus.count),    1);

        // clear during DRAIN restarts the full window
        go(0, 0, 1, 0);
        go(1, 0, 0, 0);
        go(1, 0, 0, 0);
        go(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            go(1, 0, 0, 0);
            chk("reclr_ready", int'(bus.reqReady), 0);
        end
        go(1, 0, 0, 0);
        chk("reclr_resume", int'(bus.reqReady), 1);

        // 5: retire on empty sets sticky underflow
        go(0, 0, 0, 1);
        go(0, 1, 0, 0);
        go(0, 0, 0, 0);
        chk("t5_underflow", int'(bus.underflow), 1);
        chk("t5_count",     int'(bus.count),     0);
        for (int i = 0; i < 3; i++) go(1, 0, 0, 0);
        go(0, 0, 1, 0);
        go(0, 0, 0, 0);
        chk("t5_sticky", int'(bus.underflow), 1);
        go(0, 0, 0, 1);
        go(0, 0, 0, 0);
        chk("t5_rst_clears", int'(bus.underflow), 0);

        // 6: reset mid-DRAIN returns to RUN
        for (int i = 0; i < 3; i++) go(1, 0, 0, 0);
        go(0, 0, 1, 0);
        go(0, 0, 0, 0);
        chk("t6_draining", int'(bus.draining), 1);
        go(0, 0, 0, 1);
        go(0, 0, 0, 0);
        chk("t6_draining_rst", int'(bus.draining), 0);
        chk("t6_ready",        int'(bus.reqReady), 1);
        chk("t6_robIdx",       int'(bus.robIdx),   0);
        chk("t6_count",        int'(bus.count),    0);
        chk("t6_full",         int'(bus.full),     0);
        chk("t6_empty",        int'(bus.empty),    1);
        chk("t6_underflow",    int'(bus.underflow),0);

        go(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
